// File: rtl/microcode_sequencer.sv
// ---------------------------------------------------------------------------
// microcode_sequencer
//
// Purpose:
//   Owns the micro-program counter (upc) of a microprogrammed control unit.
//   Every cycle it picks the next micro-address from one of three sources:
//   the sequential next-address field of the current microinstruction, an
//   opcode dispatch through the instruction register, or the JMPNZ
//   not-taken redirect. It also holds the instruction register opcode and
//   the Z flag, and adds stall, halt and an illegal-opcode trap.
//
// Optional feature:
//   SEQ_PERF_CNT_EN - when defined, adds two saturating 16-bit performance
//   counters (committed dispatches, stalled cycles) and their output ports.
//
// Ports:
//   clk           in   1   rising-edge clock
//   reset_n       in   1   asynchronous active-low reset
//   stall         in   1   freezes all state while high
//   upc           out  AW  current micro-address to the control store
//   u_na          in   AW  next-address field of the current microinstruction
//   u_br          in   1   1 = dispatch on opcode, 0 = take u_na
//   u_ir_ld       in   1   load IR from mem_opcode this cycle
//   u_z_ld        in   1   load Z from alu_zero this cycle
//   u_halt        in   1   halt microinstruction
//   mem_opcode    in   AW  opcode bits from the memory data bus
//   alu_zero      in   1   ALU zero result
//   ir_q          out  AW  registered opcode
//   z_q           out  1   registered Z flag
//   dispatch      out  1   one-cycle pulse after a dispatch commits
//   halted        out  1   sticky halt status
//   illegal       out  1   sticky illegal-opcode status
//   perf_dispatch out  16  committed dispatch count (SEQ_PERF_CNT_EN only)
//   perf_stall    out  16  stalled-edge count      (SEQ_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module microcode_sequencer #(
  parameter int            AW             = 5,
  parameter logic [AW-1:0] TRAP_ADDR      = AW'(31),
  parameter logic [AW-1:0] JMPNZ_OP       = AW'(10),
  parameter logic [AW-1:0] JMPNZ_NOTTAKEN = AW'(13)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stall,
  output logic [AW-1:0] upc,
  input  logic [AW-1:0] u_na,
  input  logic          u_br,
  input  logic          u_ir_ld,
  input  logic          u_z_ld,
  input  logic          u_halt,
  input  logic [AW-1:0] mem_opcode,
  input  logic          alu_zero,
  output logic [AW-1:0] ir_q,
  output logic          z_q,
  output logic          dispatch,
  output logic          halted,
  output logic          illegal
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]   perf_dispatch,
  output logic [15:0]   perf_stall
`endif
);

  // Source of the next micro-address chosen for the coming edge.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_NA,
    SEL_TRAP,
    SEL_NOTTAKEN,
    SEL_IR
  } nextSel_e;

  nextSel_e      nextSel;
  logic          advance;
  logic          brCommit;
  logic [AW-1:0] upc_q, upc_d;
  logic [AW-1:0] ir_d;
  logic          z_d;
  logic          dispatch_q, dispatch_d;
  logic          halted_q, halted_d;
  logic          illegal_q, illegal_d;

  // Opcodes 0 and 1 alias the fetch micro-routine, so dispatching on them
  // would re-enter fetch mid-way; they are routed to the trap instead.
  // Halt and stall both freeze sequencing; stall is checked first so that
  // a halt issued during a stall only lands on the first unstalled edge.
  always_comb begin
    nextSel   = SEL_HOLD;
    halted_d  = halted_q;
    advance   = ~halted_q & ~stall;
    if (advance) begin
      if (u_halt) begin
        nextSel  = SEL_HOLD;
        halted_d = 1'b1;
      end else if (!u_br) begin
        nextSel = SEL_NA;
      end else if (ir_q == AW'(0) || ir_q == AW'(1)) begin
        nextSel = SEL_TRAP;
      end else if (ir_q == JMPNZ_OP && z_q) begin
        nextSel = SEL_NOTTAKEN;
      end else begin
        nextSel = SEL_IR;
      end
    end
  end

  // Turn the chosen source into the next register values. Dispatch always
  // reads the pre-edge ir_q/z_q, so a same-cycle IR or Z load only becomes
  // visible to the following microinstruction.
  always_comb begin
    upc_d      = upc_q;
    ir_d       = ir_q;
    z_d        = z_q;
    illegal_d  = illegal_q;
    brCommit   = 1'b0;
    case (nextSel)
      SEL_NA:       upc_d = u_na;
      SEL_TRAP: begin
        upc_d     = TRAP_ADDR;
        illegal_d = 1'b1;
        brCommit  = 1'b1;
      end
      SEL_NOTTAKEN: begin
        upc_d    = JMPNZ_NOTTAKEN;
        brCommit = 1'b1;
      end
      SEL_IR: begin
        upc_d    = ir_q;
        brCommit = 1'b1;
      end
      default:      upc_d = upc_q;
    endcase
    if (advance && u_ir_ld) begin
      ir_d = mem_opcode;
    end
    if (advance && u_z_ld) begin
      z_d = alu_zero;
    end
    dispatch_d = brCommit;
  end

  // Sequencer state registers. Reset is asynchronous and overrides stall
  // and halt; halted and illegal are sticky until the next reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upc_q      <= '0;
      ir_q       <= '0;
      z_q        <= 1'b0;
      dispatch_q <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      upc_q      <= upc_d;
      ir_q       <= ir_d;
      z_q        <= z_d;
      dispatch_q <= dispatch_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
    end
  end

  assign upc      = upc_q;
  assign dispatch = dispatch_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] perfDispatch_q;
  logic [15:0] perfStall_q;

  // Saturating event counters. A stalled edge is only counted while the
  // sequencer is still running, since a halted machine has nothing to wait on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perfDispatch_q <= '0;
      perfStall_q    <= '0;
    end else begin
      if (brCommit && perfDispatch_q != 16'hFFFF) begin
        perfDispatch_q <= perfDispatch_q + 16'd1;
      end
      if (stall && !halted_q && perfStall_q != 16'hFFFF) begin
        perfStall_q <= perfStall_q + 16'd1;
      end
    end
  end

  assign perf_dispatch = perfDispatch_q;
  assign perf_stall    = perfStall_q;
`else
  // Without the performance counters the sequencer carries no extra state.
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_microcode_sequencer
//
// Purpose:
//   Self-checking bench for microcode_sequencer. The bench plays the role of
//   the control store by driving the microinstruction fields directly, and
//   keeps a behavioural model of the sequencing rules to predict every
//   output after each clock edge. Directed steps follow the test plan, then
//   randomized traffic exercises the dispatch paths, and the run ends with
//   the halt sequence. Define SEQ_PERF_CNT_EN to also check the counters.
// ---------------------------------------------------------------------------
module tb_microcode_sequencer;

  logic       clk;
  logic       reset_n;
  logic       stall;
  logic [4:0] upc;
  logic [4:0] u_na;
  logic       u_br;
  logic       u_ir_ld;
  logic       u_z_ld;
  logic       u_halt;
  logic [4:0] mem_opcode;
  logic       alu_zero;
  logic [4:0] ir_q;
  logic       z_q;
  logic       dispatch;
  logic       halted;
  logic       illegal;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] perf_dispatch;
  logic [15:0] perf_stall;
`endif

  int testsRun  = 0;
  int failCount = 0;

  int mUpc, mIr, mZ, mDispatch, mHalted, mIllegal;
  int mCntDispatch, mCntStall;

  microcode_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .upc        (upc),
    .u_na       (u_na),
    .u_br       (u_br),
    .u_ir_ld    (u_ir_ld),
    .u_z_ld     (u_z_ld),
    .u_halt     (u_halt),
    .mem_opcode (mem_opcode),
    .alu_zero   (alu_zero),
    .ir_q       (ir_q),
    .z_q        (z_q),
    .dispatch   (dispatch),
    .halted     (halted),
    .illegal    (illegal)
`ifdef SEQ_PERF_CNT_EN
    ,
    .perf_dispatch (perf_dispatch),
    .perf_stall    (perf_stall)
`endif
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Compare every DUT output against the model's current view.
  task automatic checkAll(input string phase);
    checkOutput({phase, ".upc"},      32'(upc),      32'(mUpc));
    checkOutput({phase, ".ir"},       32'(ir_q),     32'(mIr));
    checkOutput({phase, ".z"},        32'(z_q),      32'(mZ));
    checkOutput({phase, ".dispatch"}, 32'(dispatch), 32'(mDispatch));
    checkOutput({phase, ".halted"},   32'(halted),   32'(mHalted));
    checkOutput({phase, ".illegal"},  32'(illegal),  32'(mIllegal));
`ifdef SEQ_PERF_CNT_EN
    checkOutput({phase, ".perfDispatch"}, 32'(perf_dispatch), 32'(sat16(mCntDispatch)));
    checkOutput({phase, ".perfStall"},    32'(perf_stall),    32'(sat16(mCntStall)));
`endif
  endtask

  task automatic modelReset();
    mUpc = 0; mIr = 0; mZ = 0; mDispatch = 0; mHalted = 0; mIllegal = 0;
    mCntDispatch = 0; mCntStall = 0;
  endtask

  // Drive one microinstruction for one clock, predict the result from the
  // sequencing rules, and check all outputs shortly after the edge.
  task automatic applyStimulus(input bit st, input bit br, input bit halt,
                               input bit irLd, input bit zLd,
                               input int na, input int op, input bit az,
                               input string phase);
    int nUpc, nIr, nZ, nDispatch, nHalted, nIllegal;
    stall      = st;
    u_br       = br;
    u_halt     = halt;
    u_ir_ld    = irLd;
    u_z_ld     = zLd;
    u_na       = 5'(na);
    mem_opcode = 5'(op);
    alu_zero   = az;
    nUpc = mUpc; nIr = mIr; nZ = mZ; nHalted = mHalted; nIllegal = mIllegal;
    nDispatch = 0;
    if (st && mHalted == 0) mCntStall++;
    if (mHalted == 0 && !st) begin
      if (halt) nHalted = 1;
      else if (!br) nUpc = na;
      else begin
        nDispatch = 1;
        mCntDispatch++;
        if (mIr < 2) begin
          nUpc = 31;
          nIllegal = 1;
        end else if (mIr == 10 && mZ == 1) nUpc = 13;
        else nUpc = mIr;
      end
      if (irLd) nIr = op;
      if (zLd) nZ = az;
    end
    @(posedge clk);
    #1;
    mUpc = nUpc; mIr = nIr; mZ = nZ; mDispatch = nDispatch;
    mHalted = nHalted; mIllegal = nIllegal;
    checkAll(phase);
  endtask

  task automatic randomStep(input string phase);
    int op;
    op = (($urandom_range(0, 3)) == 0) ? 10 : int'($urandom_range(0, 31));
    applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'b0,
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  int'($urandom_range(0, 31)), op, ($urandom_range(0, 1) == 1),
                  phase);
  endtask

  initial begin
    int frozenUpc;
    reset_n = 1'b0; stall = 1'b0; u_na = '0; u_br = 1'b0; u_ir_ld = 1'b0;
    u_z_ld = 1'b0; u_halt = 1'b0; mem_opcode = '0; alu_zero = 1'b0;
    modelReset();
    #12;
    checkAll("reset");
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, "linear");
    checkOutput("linearUpc1", 32'(upc), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "linear");

    applyStimulus(0, 0, 0, 1, 0, 1, 21, 0, "loadFetch");
    applyStimulus(0, 1, 0, 0, 0, 7, 0, 0, "loadDispatch");
    checkOutput("loadDispatchUpc", 32'(upc), 32'd21);
    checkOutput("loadDispatchPulse", 32'(dispatch), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 22, 0, 0, "loadSeq");
    checkOutput("loadDispatchPulseEnd", 32'(dispatch), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 23, 0, 0, "loadSeq");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "loadSeq");

    applyStimulus(0, 0, 0, 1, 1, 5, 10, 0, "jmpnzSetup0");
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, "jmpnzTaken");
    checkOutput("jmpnzTakenUpc", 32'(upc), 32'd10);
    applyStimulus(0, 0, 0, 1, 1, 4, 10, 1, "jmpnzSetup1");
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, "jmpnzNotTaken");
    checkOutput("jmpnzNotTakenUpc", 32'(upc), 32'd13);
    checkOutput("jmpnzNotTakenPulse", 32'(dispatch), 32'd1);

    applyStimulus(0, 0, 0, 1, 0, 2, 1, 0, "illegalSetup");
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, "illegalTrap");
    checkOutput("illegalTrapUpc", 32'(upc), 32'd31);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, int'($urandom_range(0, 31)), 0, 0, "illegalSticky");
      checkOutput("illegalSticky", 32'(illegal), 32'd1);
    end

    applyStimulus(0, 0, 0, 0, 0, 22, 0, 0, "stallSetup");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 1, 1, 9, 7, 0, "stallHold");
      checkOutput("stallHoldUpc", 32'(upc), 32'd22);
    end
    applyStimulus(0, 0, 0, 0, 0, 23, 0, 0, "stallRelease");
    checkOutput("stallReleaseUpc", 32'(upc), 32'd23);

    for (int i = 0; i < 150; i++) randomStep("random1");

    stall = 1'b1;
    u_halt = 1'b1;
    reset_n = 1'b0;
    #2;
    modelReset();
    checkAll("midReset");
    @(negedge clk);
    reset_n = 1'b1;
    u_halt = 1'b0;

    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, "perfDispatch");
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 0, 0, 3, 0, 0, "perfStall");
`ifdef SEQ_PERF_CNT_EN
    checkOutput("perfDispatchFour", 32'(perf_dispatch), 32'd4);
    checkOutput("perfStallSeven", 32'(perf_stall), 32'd7);
`endif

    for (int i = 0; i < 150; i++) randomStep("random2");

    applyStimulus(1, 0, 1, 0, 0, 5, 0, 0, "haltStalled");
    applyStimulus(1, 0, 1, 0, 0, 5, 0, 0, "haltStalled");
    checkOutput("haltWaitsForStall", 32'(halted), 32'd0);
    applyStimulus(0, 0, 1, 0, 0, 5, 0, 0, "haltTake");
    checkOutput("haltTaken", 32'(halted), 32'd1);
    frozenUpc = int'(upc);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'(i), 1'(i >> 1), 0, 1, 1, int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), 1, "haltFrozen");
      checkOutput("haltFrozenUpc", 32'(upc), 32'(frozenUpc));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
